// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I single-port handshake.
// Accepts one request, waits LATENCY cycles, performs a byte-masked access and pulses mem_resp.
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] mem_address_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_byte_enable_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_resp_o,
    output logic        mem_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int          DEPTH  = 2 ** ADDR_BITS;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;

    logic [ADDR_BITS-1:0] idx_q;
    logic [31:0]          wdata_q;
    logic [3:0]           be_q;
    logic                 rd_q;
    logic                 wr_q;
    logic                 oob_q;

    logic                 err_q;
    logic [31:0]          rdata_q;
    logic [31:0]          mem_q [DEPTH];

    logic                 req;
    logic                 in_idle;
    logic                 accept;
    logic                 access;
    logic [ADDR_BITS-1:0] req_idx;
    logic                 req_oob;

    logic [ADDR_BITS-1:0] acc_idx;
    logic [31:0]          acc_wdata;
    logic [3:0]           acc_be;
    logic                 acc_rd;
    logic                 acc_wr;
    logic                 acc_oob;
    logic                 acc_both;
    logic                 acc_err;
    logic                 addr_unused;

    assign addr_unused = ^mem_address_i[1:0];

    assign req     = mem_read_i | mem_write_i;
    assign in_idle = (state_q == IDLE);
    assign req_idx = mem_address_i[ADDR_BITS+1:2];
    assign req_oob = |(mem_address_i >> (ADDR_BITS + 2));
    assign accept  = in_idle && req;

    // With LATENCY=1 the access happens on the acceptance edge, so it must use the live inputs.
    assign access = (accept && (LATENCY == 1))
                 || ((state_q == WAIT) && req && (cnt_q == 4'd1));

    assign acc_idx   = in_idle ? req_idx           : idx_q;
    assign acc_wdata = in_idle ? mem_wdata_i       : wdata_q;
    assign acc_be    = in_idle ? mem_byte_enable_i : be_q;
    assign acc_rd    = in_idle ? mem_read_i        : rd_q;
    assign acc_wr    = in_idle ? mem_write_i       : wr_q;
    assign acc_oob   = in_idle ? req_oob           : oob_q;
    assign acc_both  = acc_rd & acc_wr;
    assign acc_err   = acc_both | acc_oob;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                // Dropping both request lines abandons the transaction silently.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        mem_resp_o  = (state_q == RESP);
        mem_err_o   = (state_q == RESP) && err_q;
        mem_rdata_o = rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            oob_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= mem_wdata_i;
            be_q    <= mem_byte_enable_i;
            rd_q    <= mem_read_i;
            wr_q    <= mem_write_i;
            oob_q   <= req_oob;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else if (access) begin
            err_q <= acc_err;
            if (acc_both) begin
                rdata_q <= 32'd0;
            end else if (acc_rd) begin
                rdata_q <= acc_oob ? 32'd0 : mem_q[acc_idx];
            end
        end
    end

    // The word array is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (access && acc_wr && !acc_rd && !acc_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
